// File: rtl/game_countdown_timer.sv
// BCD minutes:seconds round timer that counts down on 1 s ticks, with load/start/pause control.
// Optional GAME_COUNTDOWN_TIMER_WARN_EN adds a blinking low-time warning output.
module game_countdown_timer #(
    parameter logic [3:0] DEF_MIN   = 4'd1,
    parameter logic [2:0] DEF_SEC_T = 3'd3,
    parameter logic [3:0] DEF_SEC_O = 4'd0
`ifdef GAME_COUNTDOWN_TIMER_WARN_EN
    ,
    parameter logic [5:0] WARN_SECS = 6'd10
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       OnesecTimeout,
    input  logic       load,
    input  logic [3:0] preset_min,
    input  logic [2:0] preset_sec_t,
    input  logic [3:0] preset_sec_o,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] min_bcd,
    output logic [2:0] sec_t_bcd,
    output logic [3:0] sec_o_bcd,
    output logic       running,
    output logic       expired,
    output logic       expire_pulse
`ifdef GAME_COUNTDOWN_TIMER_WARN_EN
    ,
    output logic       warn
`endif
);

    // state   | meaning
    // IDLE    | value loaded, not counting
    // RUN     | counting down on each tick
    // PAUSED  | value held, resumable
    // EXPIRED | value 0:00, left only via load/rst
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t     state_q;
    logic [3:0] min_q;
    logic [2:0] sec_t_q;
    logic [3:0] sec_o_q;
    logic       running_q;
    logic       expired_q;
    logic       expire_pulse_q;

    logic [3:0] dec_min_d;
    logic [2:0] dec_sec_t_d;
    logic [3:0] dec_sec_o_d;
    logic [3:0] ld_min_d;
    logic [2:0] ld_sec_t_d;
    logic [3:0] ld_sec_o_d;
    logic       is_zero;
    logic       last_sec;

    always_comb begin
        ld_min_d   = (preset_min   > 4'd9) ? 4'd9 : preset_min;
        ld_sec_t_d = (preset_sec_t > 3'd5) ? 3'd5 : preset_sec_t;
        ld_sec_o_d = (preset_sec_o > 4'd9) ? 4'd9 : preset_sec_o;
    end

    // BCD borrow chain; only evaluated in RUN, where the value is never 0:00
    always_comb begin
        dec_min_d   = min_q;
        dec_sec_t_d = sec_t_q;
        dec_sec_o_d = sec_o_q;
        if (sec_o_q != 4'd0) begin
            dec_sec_o_d = sec_o_q - 4'd1;
        end else begin
            dec_sec_o_d = 4'd9;
            if (sec_t_q != 3'd0) begin
                dec_sec_t_d = sec_t_q - 3'd1;
            end else begin
                dec_sec_t_d = 3'd5;
                dec_min_d   = min_q - 4'd1;
            end
        end
    end

    assign is_zero  = (min_q == 4'd0) && (sec_t_q == 3'd0) && (sec_o_q == 4'd0);
    assign last_sec = (min_q == 4'd0) && (sec_t_q == 3'd0) && (sec_o_q == 4'd1);

`ifdef GAME_COUNTDOWN_TIMER_WARN_EN
    logic       warn_q;
    logic [9:0] dec_total_d;
    logic       warn_zone;

    assign dec_total_d = ({6'd0, dec_min_d} * 10'd60) + ({7'd0, dec_sec_t_d} * 10'd10)
                         + {6'd0, dec_sec_o_d};
    assign warn_zone   = (dec_total_d <= {4'd0, WARN_SECS});
    assign warn        = warn_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            min_q          <= DEF_MIN;
            sec_t_q        <= DEF_SEC_T;
            sec_o_q        <= DEF_SEC_O;
            running_q      <= 1'b0;
            expired_q      <= 1'b0;
            expire_pulse_q <= 1'b0;
`ifdef GAME_COUNTDOWN_TIMER_WARN_EN
            warn_q         <= 1'b0;
`endif
        end else begin
            expire_pulse_q <= 1'b0;
            if (load) begin
                state_q   <= IDLE;
                min_q     <= ld_min_d;
                sec_t_q   <= ld_sec_t_d;
                sec_o_q   <= ld_sec_o_d;
                running_q <= 1'b0;
                expired_q <= 1'b0;
`ifdef GAME_COUNTDOWN_TIMER_WARN_EN
                warn_q    <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE, PAUSED: begin
                        if (start) begin
                            if (is_zero) begin
                                state_q        <= EXPIRED;
                                expired_q      <= 1'b1;
                                expire_pulse_q <= 1'b1;
`ifdef GAME_COUNTDOWN_TIMER_WARN_EN
                                warn_q         <= 1'b1;
`endif
                            end else begin
                                state_q   <= RUN;
                                running_q <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state_q   <= PAUSED;
                            running_q <= 1'b0;
                        end else if (OnesecTimeout) begin
                            min_q   <= dec_min_d;
                            sec_t_q <= dec_sec_t_d;
                            sec_o_q <= dec_sec_o_d;
`ifdef GAME_COUNTDOWN_TIMER_WARN_EN
                            if (warn_zone) begin
                                warn_q <= ~warn_q;
                            end
`endif
                            if (last_sec) begin
                                state_q        <= EXPIRED;
                                running_q      <= 1'b0;
                                expired_q      <= 1'b1;
                                expire_pulse_q <= 1'b1;
`ifdef GAME_COUNTDOWN_TIMER_WARN_EN
                                warn_q         <= 1'b1;
`endif
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign min_bcd      = min_q;
    assign sec_t_bcd    = sec_t_q;
    assign sec_o_bcd    = sec_o_q;
    assign running      = running_q;
    assign expired      = expired_q;
    assign expire_pulse = expire_pulse_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer: load/start/pause/tick sequences with hand-computed values.
module tb_game_countdown_timer;

    logic       clk;
    logic       rst;
    logic       OnesecTimeout;
    logic       load;
    logic [3:0] preset_min;
    logic [2:0] preset_sec_t;
    logic [3:0] preset_sec_o;
    logic       start;
    logic       pause;
    logic [3:0] min_bcd;
    logic [2:0] sec_t_bcd;
    logic [3:0] sec_o_bcd;
    logic       running;
    logic       expired;
    logic       expire_pulse;
`ifdef GAME_COUNTDOWN_TIMER_WARN_EN
    logic       warn;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    game_countdown_timer dut (
        .clk           (clk),
        .rst           (rst),
        .OnesecTimeout (OnesecTimeout),
        .load          (load),
        .preset_min    (preset_min),
        .preset_sec_t  (preset_sec_t),
        .preset_sec_o  (preset_sec_o),
        .start         (start),
        .pause         (pause),
        .min_bcd       (min_bcd),
        .sec_t_bcd     (sec_t_bcd),
        .sec_o_bcd     (sec_o_bcd),
        .running       (running),
        .expired       (expired),
        .expire_pulse  (expire_pulse)
`ifdef GAME_COUNTDOWN_TIMER_WARN_EN
        ,
        .warn          (warn)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    task automatic chk_val(input string tag, input int m, input int t, input int o);
        chk({tag, "_min"}, int'(min_bcd), m);
        chk({tag, "_sec_t"}, int'(sec_t_bcd), t);
        chk({tag, "_sec_o"}, int'(sec_o_bcd), o);
    endtask

    task automatic chk_flags(input string tag, input int r, input int e, input int p);
        chk({tag, "_running"}, int'(running), r);
        chk({tag, "_expired"}, int'(expired), e);
        chk({tag, "_pulse"}, int'(expire_pulse), p);
    endtask

    // One clock with the given control inputs held; outputs are stable #1 after the edge.
    task automatic drive(input logic ld, input logic st, input logic ps, input logic tk);
        load          = ld;
        start         = st;
        pause         = ps;
        OnesecTimeout = tk;
        @(posedge clk);
        #1;
        load          = 1'b0;
        start         = 1'b0;
        pause         = 1'b0;
        OnesecTimeout = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] m, input logic [2:0] t, input logic [3:0] o);
        preset_min   = m;
        preset_sec_t = t;
        preset_sec_o = o;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        OnesecTimeout = 1'b0;
        load = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        preset_min = 4'd0;
        preset_sec_t = 3'd0;
        preset_sec_o = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_val("reset", 1, 3, 0);
        chk_flags("reset", 0, 0, 0);
        rst = 1'b0;

        do_load(4'd0, 3'd0, 4'd3);
        chk_val("ld003", 0, 0, 3);
        chk("ld003_running", int'(running), 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("start003_running", int'(running), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_val("t1", 0, 0, 2);
        chk("t1_expired", int'(expired), 0);
        idle_cycles(19);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_val("t2", 0, 0, 1);
        idle_cycles(19);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_val("t3", 0, 0, 0);
        chk_flags("t3", 0, 1, 1);
        idle_cycles(1);
        chk_flags("t3_after", 0, 1, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_val("t4", 0, 0, 0);
        chk_flags("t4", 0, 1, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk_flags("exp_start", 0, 1, 0);

        do_load(4'd1, 3'd0, 4'd0);
        chk("ld100_expired", int'(expired), 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_val("b100", 0, 5, 9);
        do_load(4'd0, 3'd1, 4'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_val("b010", 0, 0, 9);

        do_load(4'd0, 3'd3, 4'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycles(3);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_val("p028", 0, 2, 8);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pause_running", int'(running), 0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_val("paused_ticks", 0, 2, 8);
        chk("paused_running", int'(running), 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("resume_running", int'(running), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_val("p027", 0, 2, 7);

        do_load(4'd0, 3'd0, 4'd5);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        chk("st_tick_running", int'(running), 1);
        chk_val("st_tick", 0, 0, 5);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_val("st_tick_next", 0, 0, 4);
        do_load(4'd0, 3'd2, 4'd1);
        chk("ld_in_run_running", int'(running), 0);
        chk_val("ld_in_run", 0, 2, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_val("idle_tick", 0, 2, 1);

        // start+pause both orders, and pause beating a same-cycle tick
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        chk("run_sp_running", int'(running), 0);
        chk_val("run_sp", 0, 2, 1);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("paused_sp_running", int'(running), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_val("borrow_t", 0, 1, 9);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        chk("ld_prio_running", int'(running), 0);

        do_load(4'd11, 3'd7, 4'd12);
        chk_val("clamp", 9, 5, 9);
        do_load(4'd0, 3'd0, 4'd0);
        chk_flags("ld000", 0, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk_flags("start000", 0, 1, 1);
        idle_cycles(1);
        chk_flags("start000_after", 0, 1, 0);

`ifdef GAME_COUNTDOWN_TIMER_WARN_EN
        do_load(4'd0, 3'd1, 4'd2);
        chk("warn_ld", int'(warn), 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("warn_011", int'(warn), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("warn_010", int'(warn), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("warn_009", int'(warn), 0);
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_val("warn_end", 0, 0, 0);
        chk("warn_exp", int'(warn), 1);
`endif

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_val("rst2", 1, 3, 0);
        chk_flags("rst2", 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
